// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffered issue stage in front of a combinational ALU.
//   Requests (opcode, op1, op2, tag) enter over in_valid/in_ready into a
//   DEPTH-entry FIFO. The FIFO head drives the ALU inputs combinationally.
//   The ALU result is captured with the head tag into a single output slot
//   that hands off to writeback over out_valid/out_ready.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           request handshake (in_ready = count < DEPTH)
//   in_opcode/in_op1/in_op2     request opcode and operands
//   in_tag                      request tag, returned with the result
//   alu_operand1/2, alu_opcode  head entry to the ALU (zero when empty)
//   alu_result                  combinational result from the ALU
//   out_valid/out_ready         result handshake
//   out_result/out_tag          registered result and its tag
//   out_illegal                 result's opcode was outside 0001..0101
//   count                       FIFO occupancy
module alu_issue_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_opcode,
  input  logic [WIDTH-1:0]           in_op1,
  input  logic [WIDTH-1:0]           in_op2,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [WIDTH-1:0]           alu_operand1,
  output logic [WIDTH-1:0]           alu_operand2,
  output logic [3:0]                 alu_opcode,
  input  logic [WIDTH-1:0]           alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           enq;
  logic           deq;
  logic           slot_free;
  logic           not_empty;
  logic           head_illegal;

  // Handshake decisions; in_ready depends on registered count only.
  always_comb begin
    in_ready     = (count < CW'(DEPTH));
    not_empty    = (count != '0);
    slot_free    = !out_valid || out_ready;
    enq          = in_valid && in_ready;
    deq          = not_empty && slot_free;
    head         = mem[rd_ptr];
    head_illegal = (head.opcode == 4'd0) || (head.opcode > 4'd5);
  end

  // Head entry to the ALU; idle inputs are zero when the queue is empty.
  always_comb begin
    alu_operand1 = '0;
    alu_operand2 = '0;
    alu_opcode   = 4'd0;
    if (not_empty) begin
      alu_operand1 = head.op1;
      alu_operand2 = head.op2;
      alu_opcode   = head.opcode;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{opcode: in_opcode, op1: in_op1, op2: in_op2, tag: in_tag};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output slot: load on dequeue, empty on handoff with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (deq) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_tag     <= head.tag;
      out_illegal <= head_illegal;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a combinational ALU model.
module tb_alu_issue_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] alu_operand1;
  logic [WIDTH-1:0] alu_operand2;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [$clog2(DEPTH):0] count;

  int passed = 0;
  int total  = 0;

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_opcode(alu_opcode), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // External ALU stand-in.
  always_comb alu_result = ref_alu(alu_opcode, alu_operand1, alu_operand2);

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t);
    in_valid  = v;
    in_opcode = op;
    in_op1    = a;
    in_op2    = b;
    in_tag    = t;
  endtask

  logic [31:0] s_exp [4];
  logic [31:0] b_a   [5];
  logic [31:0] b_exp [5];
  logic [31:0] sb_res[$];
  logic [3:0]  sb_tag[$];
  logic [31:0] wa, wb;
  logic [3:0]  wop;
  int          sent, recv, cyc;

  initial begin
    s_exp[0] = 32'h0E100E10; s_exp[1] = 32'h000F000F;
    s_exp[2] = 32'h0FFF0FFF; s_exp[3] = 32'h0FF00FF0;
    b_a[0] = 32'h10; b_a[1] = 32'h20; b_a[2] = 32'h30; b_a[3] = 32'h40; b_a[4] = 32'h50;
    b_exp[0] = 32'h11; b_exp[1] = 32'h22; b_exp[2] = 32'h33; b_exp[3] = 32'h44; b_exp[4] = 32'h55;

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    rst_n = 1'b1;

    // Single op: add wraps to zero, two edges of latency
    @(negedge clk);
    drive(1'b1, OP_ADD, 32'hFFFFFFFF, 32'h1, 4'd3);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    chk("single_count1", 64'(count), 64'd1);
    chk("single_alu_op", 64'(alu_opcode), 64'(OP_ADD));
    chk("single_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_result", 64'(out_result), 64'h0);
    chk("single_tag", 64'(out_tag), 64'd3);
    chk("single_illegal", 64'(out_illegal), 64'd0);
    chk("single_count0", 64'(count), 64'd0);
    @(negedge clk);
    chk("single_drained", 64'(out_valid), 64'd0);

    // Streaming sub/and/or/xor, one result per cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_result", 64'(out_result), 64'(s_exp[k-2]));
        chk("stream_tag", 64'(out_tag), 64'(k-2));
      end
      if (k >= 1 && k <= 4) chk("stream_count", 64'(count), 64'd1);
      if (k < 4) drive(1'b1, 4'(OP_SUB + k), 32'h0F0F0F0F, 32'h00FF00FF, 4'(k));
      else       drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    end
    @(negedge clk);
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: fill queue behind a held slot
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, OP_ADD, b_a[i], 32'(i + 1), 4'(8 + i));
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    chk("bp_count_full", 64'(count), 64'd4);
    chk("bp_in_ready0", 64'(in_ready), 64'd0);
    chk("bp_slot_valid", 64'(out_valid), 64'd1);
    chk("bp_slot_result", 64'(out_result), 64'(b_exp[0]));
    chk("bp_slot_tag", 64'(out_tag), 64'd8);
    @(negedge clk);
    chk("bp_slot_stable", 64'(out_result), 64'(b_exp[0]));
    chk("bp_count_held", 64'(count), 64'd4);
    // Release while offering an extra request that must not be admitted
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'h99, 32'h1, 4'd15);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    chk("bp_count3", 64'(count), 64'd3);
    chk("bp_in_ready1", 64'(in_ready), 64'd1);
    chk("bp_result1", 64'(out_result), 64'(b_exp[1]));
    chk("bp_tag1", 64'(out_tag), 64'd9);
    for (int j = 2; j < 5; j++) begin
      @(negedge clk);
      chk("bp_result", 64'(out_result), 64'(b_exp[j]));
      chk("bp_tag", 64'(out_tag), 64'(8 + j));
      chk("bp_count", 64'(count), 64'(4 - j));
    end
    @(negedge clk);
    chk("bp_no_extra", 64'(out_valid), 64'd0);

    // Illegal opcode passes through, next legal op clears the flag
    @(negedge clk);
    drive(1'b1, 4'hF, 32'h5, 32'h6, 4'd7);
    @(negedge clk);
    drive(1'b1, OP_XOR, 32'hA, 32'h3, 4'd1);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_result", 64'(out_result), 64'd0);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_tag", 64'(out_tag), 64'd7);
    @(negedge clk);
    chk("legal_result", 64'(out_result), 64'h9);
    chk("legal_flag", 64'(out_illegal), 64'd0);
    chk("legal_tag", 64'(out_tag), 64'd1);

    // Reset in the middle of traffic
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'h1, 32'h1, 4'd2);
    @(negedge clk);
    drive(1'b1, OP_ADD, 32'h2, 32'h2, 4'd4);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_result", 64'(out_result), 64'd0);
    chk("mid_rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    drive(1'b1, OP_SUB, 32'd10, 32'd3, 4'd5);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("post_rst_result", 64'(out_result), 64'd7);
    chk("post_rst_tag", 64'(out_tag), 64'd5);
    @(negedge clk);
    chk("post_rst_drained", 64'(out_valid), 64'd0);

    // Wrap-around with random stalls against a scoreboard
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 3 * DEPTH + 1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 3 * DEPTH + 1) begin
        wop = (sent % 2 == 1) ? OP_XOR : OP_ADD;
        wa  = 32'(sent) * 32'h01010101;
        wb  = 32'h00000100 + 32'(sent);
        drive(1'b1, wop, wa, wb, 4'(sent));
      end else begin
        drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
      end
      if (out_valid && out_ready) begin
        if (sb_res.size() == 0) begin
          chk("wrap_unexpected", 64'(out_valid), 64'd0);
        end else begin
          chk("wrap_result", 64'(out_result), 64'(sb_res.pop_front()));
          chk("wrap_tag", 64'(out_tag), 64'(sb_tag.pop_front()));
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        sb_res.push_back(ref_alu(wop, wa, wb));
        sb_tag.push_back(4'(sent));
        sent++;
      end
    end
    chk("wrap_all_received", 64'(recv), 64'(3 * DEPTH + 1));
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("wrap_count_empty", 64'(count), 64'd0);
    chk("wrap_no_dup", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
